// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: transmitter state
// encoding, keyboard command bytes, default bus timing and frame helpers.
package ps2_pkg;

    // Host transmitter sequence states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        ERROR     = 3'd6
    } ps2_tx_state_e;

    // Common host-to-keyboard commands and the keyboard's acknowledge byte
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Default timing in 50 MHz cycles
    localparam int unsigned PS2_INHIBIT_CYCLES = 32'd6000;    // 120 us
    localparam int unsigned PS2_START_TIMEOUT  = 32'd750000;  // 15 ms
    localparam int unsigned PS2_PACKET_TIMEOUT = 32'd100000;  // 2 ms
    localparam int unsigned PS2_CNT_W          = 32'd20;

    // Level an undriven (pulled-up) line settles at
    localparam logic PS2_LINE_IDLE = 1'b1;

    // Odd parity bit: makes the count of ones over data+parity odd
    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Bits presented on successive device falling edges, LSB first:
    // data[0..7], parity, then the stop bit (line released)
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] d);
        return {1'b1, ps2_odd_parity(d), d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data lines, plus a
// single-cycle pulse on each falling edge of the synchronised clock.
// Shared between the host transmitter and the scan-code receiver.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic clk_fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Resynchronise both lines; idle-high reset avoids a false edge at start-up
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= {PS2_LINE_IDLE, PS2_LINE_IDLE};
            dat_sync_q <= {PS2_LINE_IDLE, PS2_LINE_IDLE};
            clk_prev_q <= PS2_LINE_IDLE;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s_o    = clk_sync_q[1];
    assign dat_s_o    = dat_sync_q[1];
    assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Runs the inhibit /
// request-to-send handshake, shifts one byte plus odd parity out on the
// device's falling edges, checks the device ACK and guards the whole
// exchange with start and packet timeouts. Both bus lines are open-drain.
//
// Build option PS2_TX_ACK_CHECK_EN: when defined, a high data line at the
// eleventh falling edge (NACK) ends the transfer with tx_error; when
// undefined that edge is always taken as an acknowledge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int unsigned PACKET_TIMEOUT = PS2_PACKET_TIMEOUT,
    parameter int unsigned CNT_W          = PS2_CNT_W
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam logic [CNT_W-1:0] TIMER_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] START_LIMIT  = CNT_W'(START_TIMEOUT);
    localparam logic [CNT_W-1:0] PACKET_LIMIT = CNT_W'(PACKET_TIMEOUT);
    localparam logic [3:0]       LAST_DATA_EDGE_CNT = 4'd9;  // count before edge 10

    ps2_tx_state_e    state_q,     state_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    logic [9:0]       frame_q,     frame_d;
    logic             clk_low_q,   clk_low_d;
    logic             dat_low_q,   dat_low_d;
    logic             tx_ready_q,  tx_ready_d;
    logic             tx_done_q,   tx_done_d;
    logic             tx_error_q,  tx_error_d;
    logic             busy_q,      busy_d;

    logic             clk_s;
    logic             dat_s;
    logic             clk_fall_s;

    ps2_line_sync u_sync (
        .clk_i      (CLOCK_50),
        .rst_n_i    (Resetn),
        .ps2_clk_i  (PS2_CLK),
        .ps2_dat_i  (PS2_DAT),
        .clk_s_o    (clk_s),
        .dat_s_o    (dat_s),
        .clk_fall_o (clk_fall_s)
    );

    // Open-drain pads: only ever pull low or let go
    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    assign tx_ready = tx_ready_q;
    assign tx_done  = tx_done_q;
    assign tx_error = tx_error_q;
    assign busy     = busy_q;

    // Next-state, timer, shifter and pad-drive decisions for the handshake
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        clk_low_d  = clk_low_q;
        dat_low_d  = dat_low_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                timer_d   = '0;
                bit_cnt_d = 4'd0;
                if (tx_valid && tx_ready_q) begin
                    frame_d   = ps2_tx_frame(tx_data);
                    clk_low_d = 1'b1;
                    state_d   = INHIBIT;
                end else begin
                    state_d   = IDLE;
                end
            end

            // Hold the clock low long enough to abort any device frame
            INHIBIT: begin
                clk_low_d = 1'b1;
                if (timer_q >= INHIBIT_LAST) begin
                    // Start bit goes low while the clock is still held
                    dat_low_d = 1'b1;
                    timer_d   = '0;
                    state_d   = REQ;
                end else begin
                    dat_low_d = 1'b0;
                    timer_d   = timer_q + TIMER_ONE;
                end
            end

            // Clock released, start bit held: wait for the device to clock
            REQ: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b1;
                if (clk_fall_s) begin
                    dat_low_d = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[9:1]};
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = DATA;
                end else if (timer_q >= START_LIMIT) begin
                    dat_low_d = 1'b0;
                    state_d   = ERROR;
                end else begin
                    timer_d   = timer_q + TIMER_ONE;
                end
            end

            // Each falling edge presents the next frame bit until the stop bit
            DATA: begin
                clk_low_d = 1'b0;
                if (timer_q >= PACKET_LIMIT) begin
                    dat_low_d = 1'b0;
                    state_d   = ERROR;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                    if (clk_fall_s) begin
                        dat_low_d = ~frame_q[0];
                        frame_d   = {1'b1, frame_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_DATA_EDGE_CNT) begin
                            state_d = ACK;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            // Eleventh falling edge carries the device's acknowledge
            ACK: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (timer_q >= PACKET_LIMIT) begin
                    state_d = ERROR;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                    if (clk_fall_s) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef PS2_TX_ACK_CHECK_EN
                        if (dat_s) begin
                            state_d = ERROR;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
`else
                        state_d = WAIT_IDLE;
`endif
                    end else begin
                        state_d = ACK;
                    end
                end
            end

            // Report completion only once the device has let go of both lines
            WAIT_IDLE: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (clk_s && dat_s) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = WAIT_IDLE;
                end
            end

            ERROR: begin
                clk_low_d  = 1'b0;
                dat_low_d  = 1'b0;
                tx_error_d = 1'b1;
                timer_d    = '0;
                bit_cnt_d  = 4'd0;
                state_d    = IDLE;
            end

            default: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                timer_d   = '0;
                bit_cnt_d = 4'd0;
                state_d   = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and registered outputs; reset releases both lines immediately
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= 4'd0;
            frame_q    <= 10'h3FF;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            clk_low_q  <= clk_low_d;
            dat_low_q  <= dat_low_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 keyboard on pulled-up
// open-drain lines, a table of directed transfers, random command bytes
// with a parity model, and a mid-transfer reset sequence.
module tb_ps2_host_tx;

    localparam int INH       = 60;
    localparam int START_TO  = 2000;
    localparam int PACKET_TO = 1200;
    localparam int HALF      = 15;
    localparam int MON_BOUND = INH + START_TO + PACKET_TO + 400;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit NACK_ERR = 1'b1;
`else
    localparam bit NACK_ERR = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        int         nclk;      // device clocks generated (0 = silent device)
        bit         ack;       // device pulls DAT low before edge 11
        bit         exp_done;
        bit         exp_err;
        bit         exp_par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    wire        ps2_clk, ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // device-side observations
    logic [10:0] dev_bits;
    bit          dev_req_ok;
    int          fall1_cyc, idle_cyc;
    // monitor observations
    int          mon_done, mon_err, mon_end, inh_cnt;
    bit          overlap, clk_after, busy_first, mon_timeout;
    int          acc_cyc;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (START_TO),
        .PACKET_TIMEOUT (PACKET_TO),
        .CNT_W          (20)
    ) dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .busy     (busy),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Odd parity from the bit count: even number of ones needs a 1
    function automatic bit model_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0);
    endfunction

    // Behavioural keyboard: answers a request-to-send with nclk clocks
    task automatic dev_run(input int nclk, input bit ack);
        int w;
        int last_rel;
        dev_bits   = '1;
        dev_req_ok = 1'b0;
        fall1_cyc  = -1;
        idle_cyc   = -1;
        last_rel   = -1;
        if (nclk == 0) return;
        w = 0;
        while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && w < INH + 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= INH + 40) return;
        dev_req_ok = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (3) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (k == 1) fall1_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_bits[k-1] = ps2_dat;
            dev_clk_low = 1'b0;
            last_rel = cyc;
            repeat (HALF) @(negedge clk);
        end
        if (ack && nclk == 11) begin
            dev_dat_low = 1'b0;
            idle_cyc = cyc;
        end else begin
            idle_cyc = last_rel;
        end
    endtask

    // Watches line sequencing at the start and the completion pulses
    task automatic mon_run(input int bound);
        bit dat_seen = 1'b0;
        bit want_after = 1'b0;
        mon_done = 0; mon_err = 0; mon_end = -1; inh_cnt = 0;
        overlap = 1'b0; clk_after = 1'b0; busy_first = 1'b0; mon_timeout = 1'b1;
        for (int n = 0; n < bound; n++) begin
            if (n == 0) busy_first = busy & ~tx_ready;
            if (want_after) begin
                clk_after  = (ps2_clk === 1'b1);
                want_after = 1'b0;
            end
            if (!dat_seen) begin
                if (ps2_dat === 1'b0) begin
                    dat_seen   = 1'b1;
                    overlap    = (ps2_clk === 1'b0);
                    want_after = 1'b1;
                end else if (ps2_clk === 1'b0) begin
                    inh_cnt++;
                end
            end
            if (tx_done)  mon_done++;
            if (tx_error) mon_err++;
            if ((tx_done || tx_error) && mon_end < 0) mon_end = cyc;
            if (mon_end >= 0 && cyc >= mon_end + 4) begin
                mon_timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        @(negedge clk);
        check({tag, ":ready"}, tx_ready, 1);
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        acc_cyc  = cyc;
        fork
            dev_run(v.nclk, v.ack);
            mon_run(MON_BOUND);
        join
        check({tag, ":busy"}, busy_first, 1);
        check({tag, ":inhibit_len"}, inh_cnt, INH);
        check({tag, ":dat_before_clk_rel"}, overlap, 1);
        check({tag, ":clk_released"}, clk_after, 1);
        check({tag, ":pulse_timeout"}, mon_timeout, 0);
        if (v.nclk > 0)  check({tag, ":req_seen"}, dev_req_ok, 1);
        if (v.nclk >= 8) check({tag, ":data_bits"}, dev_bits[7:0], v.data);
        if (v.nclk >= 9) check({tag, ":parity"}, dev_bits[8], v.exp_par);
        if (v.nclk >= 10) check({tag, ":stop_released"}, dev_bits[9], 1);
        check({tag, ":done_cnt"}, mon_done, v.exp_done);
        check({tag, ":err_cnt"}, mon_err, v.exp_err);
        if (v.exp_done) check_range({tag, ":done_after_idle"}, mon_end - idle_cyc, 2, 5);
        if (v.nclk == 0)
            check_range({tag, ":start_timeout"}, mon_end - acc_cyc, INH + 1 + START_TO - 3, INH + 1 + START_TO + 3);
        else if (v.exp_err && v.nclk < 10)
            check_range({tag, ":packet_timeout"}, mon_end - fall1_cyc, PACKET_TO - 3, PACKET_TO + 6);
        @(negedge clk);
        check({tag, ":lines_idle"}, {ps2_clk, ps2_dat}, 2'b11);
        check({tag, ":ready_after"}, tx_ready, 1);
        check({tag, ":busy_after"}, busy, 0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   pulses;

        vecs[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'hF4, 11, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 11, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 11, 1'b0, !NACK_ERR, NACK_ERR, 1'b1};
        vecs[4] = '{8'h5A,  5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h81,  0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst:ready", tx_ready, 1);
        check("rst:busy", busy, 0);
        check("rst:pulses", {tx_done, tx_error}, 2'b00);
        check("rst:lines", {ps2_clk, ps2_dat}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst:ready_first", tx_ready, 1);

        for (int i = 0; i < 6; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            rv.data     = 8'($urandom_range(0, 255));
            rv.nclk     = 11;
            rv.ack      = 1'b1;
            rv.exp_done = 1'b1;
            rv.exp_err  = 1'b0;
            rv.exp_par  = model_parity(rv.data);
            do_xfer(rv, $sformatf("rnd%0d", i));
        end

        // Reset while the fourth data bit (a 0) is on the line
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        dev_run(4, 1'b0);
        check("mid:req_seen", dev_req_ok, 1);
        check("mid:dat_driven", ps2_dat, 0);
        check("mid:busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid:lines", {ps2_clk, ps2_dat}, 2'b11);
        check("mid:ready", tx_ready, 1);
        check("mid:busy_clr", busy, 0);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            if (tx_done || tx_error) pulses++;
            if (i == 3) rst_n = 1'b1;
            @(negedge clk);
        end
        check("mid:no_pulse", pulses, 0);
        rv = '{8'hFF, 11, 1'b1, 1'b1, 1'b0, 1'b1};
        do_xfer(rv, "post_rst_ff");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example Set LEDs 0xED, Reset 0xFF or Enable 0xF4. It drives the shared PS2_CLK/PS2_DAT lines open-drain, next to the existing receiver that shifts in scan codes on PS2_CLK falling edges. It runs the full PS/2 request-to-send sequence, odd parity and device ACK check, with timeouts.

Parameters:
INHIBIT_CYCLES, 6000, CLOCK_50 cycles PS2_CLK is held low before request-to-send (120 us)
START_TIMEOUT, 750000, cycles allowed from CLK release to the first device falling edge (15 ms)
PACKET_TIMEOUT, 100000, cycles allowed from the first falling edge to the ACK edge (2 ms)
CNT_W, 20, timer width; must hold max(START_TIMEOUT, PACKET_TIMEOUT)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
Resetn  in  1  reset
tx_data  in  8  command byte
tx_valid  in  1  request; accepted when tx_valid & tx_ready
tx_ready  out  1  high only in IDLE
tx_done  out  1  one-cycle pulse: byte acknowledged, lines idle
tx_error  out  1  one-cycle pulse: timeout or NACK
busy  out  1  high whenever state != IDLE; the receiver ignores edges while busy
PS2_CLK  inout  1  open-drain: drive 0 or Z only
PS2_DAT  inout  1  open-drain: drive 0 or Z only

Behaviour:
- Reset: Resetn is synchronous, active-low, clocked by CLOCK_50. Reset values:
  - state IDLE, both lines Z
  - tx_ready=1 on the first cycle after reset
  - tx_done=0, tx_error=0, busy=0, timer=0, bit counter=0
  - Reset mid-transfer releases both lines on the next CLOCK_50 edge; no pulse is produced.
- Input sampling: PS2_CLK/PS2_DAT pass through 2-FF synchronisers. A falling edge is prev=1 & cur=0 on the synchronised clock, so there are 2 cycles of latency from the pin.
- Accept: on tx_valid & tx_ready, latch tx_data and compute parity = ~^tx_data (odd). Go to INHIBIT. tx_valid while busy is ignored.
- INHIBIT: drive CLK=0, DAT=Z for INHIBIT_CYCLES. This aborts any device-to-host frame in flight.
- REQ:
  - Entry: drive DAT=0 one cycle before CLK is released.
  - Hold: DAT=0, CLK=Z.
  - Exit: wait for a falling edge; the timer exceeding START_TIMEOUT → ERROR.
- DATA: on falling edge n (n=1..10) present the next bit, held until the following falling edge:
  - n=1..8: tx_data[n-1], LSB first, driven as 0 or Z
  - n=9: parity
  - n=10: release DAT (stop bit)
- ACK: on falling edge 11, sample DAT:
  - 0 = ACK → WAIT_IDLE
  - 1 = NACK → ERROR (see option)
  - The PACKET_TIMEOUT timer starts at falling edge 1; expiry in DATA or ACK → ERROR.
- WAIT_IDLE: wait until synchronised CLK=1 and DAT=1 in the same cycle. Then pulse tx_done and go to IDLE. This state has no timeout.
- ERROR: release both lines, pulse tx_error for 1 cycle, go to IDLE.
- Never drive a 1 onto either line. In IDLE both lines are Z.
- Latency, nominal: INHIBIT_CYCLES + 1 + device time (~11 device clock periods); tx_done follows bus-idle detection by 1 cycle.

Optional Feature:
PS2_TX_ACK_CHECK_EN
- Defined: DAT=1 at falling edge 11 → tx_error.
- Undefined: edge 11 is always treated as ACK and goes to WAIT_IDLE. The timeouts still apply.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, ERROR}
  - command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA
  - default timing constants
- Sub-module ps2_line_sync: 2-FF synchronisers for both lines plus the PS2_CLK falling-edge pulse. It is reusable by the receiver.

Test Plan:
1. Send 0xED with a device model that ACKs. Required:
   - CLK low for 6000 cycles, then DAT low
   - bits on edges 1..8 = 1,0,1,1,0,1,1,1; parity=1
   - DAT released at edge 10
   - tx_done one cycle after bus idle; tx_error=0
2. Send 0xF4 → parity bit=0 at edge 9. Send 0x00 → parity=1. Both end with tx_done.
3. Device never clocks → tx_error pulse at 6001+750000 cycles (±3); lines Z afterwards; tx_ready=1.
4. Device stops after 5 clocks → tx_error within PACKET_TIMEOUT of edge 1; no tx_done.
5. Device NACKs (DAT high at edge 11):
   - with PS2_TX_ACK_CHECK_EN → tx_error
   - without it → tx_done
6. Reset asserted during DATA at bit 4 → both lines Z next cycle, tx_ready=1, no pulses. A new 0xFF sent afterwards completes normally with parity 1.
